// File: rtl/apb3_pkg.sv
// Shared types for the APB3 host bridge: FSM state encoding, defaults and response record.
package apb3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb3_host_state_e;

  localparam int APB3_TIMEOUT_DEFAULT = 1024;
  localparam int APB3_DWIDTH_DEFAULT  = 32;

  typedef struct packed {
    logic [APB3_DWIDTH_DEFAULT-1:0] rdata;
    logic                           err;
  } apb3_rsp_t;

endpackage

// File: rtl/apb3_intf.sv
// APB3 bus bundle; the host drives select/enable/address/data, the agent answers.
interface apb3_intf #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AWIDTH-1:0] paddr;
  logic [DWIDTH-1:0] pwdata;
  logic [DWIDTH-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport host  (output psel, penable, pwrite, paddr, pwdata,
                 input  prdata, pready, pslverr);
  modport agent (input  psel, penable, pwrite, paddr, pwdata,
                 output prdata, pready, pslverr);
endinterface

// File: rtl/apb3_host_timer.sv
// ACCESS-phase wait counter; expire flags the TIMEOUT-th consecutive cycle without pready.
module apb3_host_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Expire fires while the last allowed wait cycle is in progress, so the
  // abort lands on the same edge the count would reach TIMEOUT.
  assign expire = en && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && !expire)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/apb3_host_bridge.sv
// APB3 initiator: one command in, one SETUP/ACCESS transfer, one registered response out.
// Optional ACCESS timeout abort when APB3_HOST_TIMEOUT_EN is defined.
module apb3_host_bridge
  import apb3_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = APB3_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  apb3_intf.host            apb
);
  typedef struct packed {
    logic [DWIDTH-1:0] rdata;
    logic              err;
  } rsp_t;

  apb3_host_state_e  state_q;
  rsp_t              rsp_q;
  logic              rsp_valid_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [AWIDTH-1:0] paddr_q;
  logic [DWIDTH-1:0] pwdata_q;
  logic              expire;

`ifdef APB3_HOST_TIMEOUT_EN
  apb3_host_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == SETUP),
    .en     ((state_q == ACCESS) && !apb.pready),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign cmd_ready   = (state_q == IDLE) && !rst;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          pwrite_q <= cmd_write;
          paddr_q  <= cmd_addr;
          pwdata_q <= cmd_wdata;
          psel_q   <= 1'b1;
          state_q  <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready has priority over a timeout expiring in the same cycle
          if (apb.pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_q.rdata <= pwrite_q ? '0 : apb.prdata;
            rsp_q.err   <= apb.pslverr;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (expire) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_q.rdata <= '0;
            rsp_q.err   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb3_host_bridge.sv
// Table-driven bench for apb3_host_bridge with a scoreboard of expected responses.
module tb_apb3_host_bridge;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;

  always #5 clk = ~clk;

  apb3_intf #(.DWIDTH(DW), .AWIDTH(AW)) apb ();

  apb3_host_bridge #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .apb(apb)
  );

  // Agent model: pready after cur_waits ACCESS cycles; junk data and a stale error while waiting.
  int            cur_waits = 0;
  int            wcnt = 0;
  logic          stuck = 1'b0, cur_err = 1'b0, cur_write = 1'b0;
  logic [DW-1:0] cur_rdata = '0, cur_wdata = '0;
  logic [AW-1:0] cur_addr = '0;

  assign apb.pready  = apb.psel && apb.penable && !stuck && (wcnt >= cur_waits);
  assign apb.prdata  = apb.pready ? cur_rdata : 32'hBAD0_BAD0;
  assign apb.pslverr = apb.pready ? cur_err : 1'b1;

  always @(posedge clk) begin
    if (!apb.penable) wcnt <= 0;
    else if (!apb.pready) wcnt <= wcnt + 1;
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string         name;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] rdata;
    logic          err;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;
  vec_t vecs[6];

  int tests = 0, fails = 0;

  function automatic vec_t mk(string nm, logic w, logic [AW-1:0] a, logic [DW-1:0] d, int ws,
                              logic [DW-1:0] rd, logic e, logic [DW-1:0] xr, logic xe);
    vec_t v;
    v.name = nm; v.write = w; v.addr = a; v.wdata = d; v.waits = ws;
    v.rdata = rd; v.err = e; v.exp_rdata = xr; v.exp_err = xe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the bridge idle; returns at the negedge of cycle T+1.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int ws, input logic [DW-1:0] rd, input logic e,
                       input logic [DW-1:0] xr, input logic xe);
    exp_t x;
    cur_waits = ws; cur_rdata = rd; cur_err = e;
    cur_addr = a; cur_write = w; cur_wdata = d;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    chk("cmd_ready", cmd_ready, 1);
    x.rdata = xr; x.err = xe;
    sbq.push_back(x);
    tick();
    cmd_valid = 1'b0;
    chk("setup", {apb.psel, apb.penable}, 2'b10);
  endtask

  task automatic finish(input string nm, input int lat);
    int   n;
    exp_t x;
    n = 1;
    while (!rsp_valid && n < 40) begin
      if (apb.psel) begin
        chk({nm, "_paddr"}, apb.paddr, cur_addr);
        chk({nm, "_pwrite"}, apb.pwrite, cur_write);
        if (cur_write) chk({nm, "_pwdata"}, apb.pwdata, cur_wdata);
      end
      tick();
      n++;
      if (n == 2) chk({nm, "_access"}, {apb.psel, apb.penable}, 2'b11);
    end
    chk({nm, "_lat"}, n, lat);
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 1, 0);
    end else begin
      x = sbq.pop_front();
      chk({nm, "_rdata"}, rsp_rdata, x.rdata);
      chk({nm, "_err"}, rsp_err, x.err);
    end
    chk({nm, "_busidle"}, {apb.psel, apb.penable}, 2'b00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({nm, "_done"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    exp_t x;
    vecs[0] = mk("wr0",     1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'h5555_5555, 1'b0, 32'h0,         1'b0);
    vecs[1] = mk("rd3",     1'b0, 32'h24, 32'h0,         3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);
    vecs[2] = mk("slverr",  1'b0, 32'h30, 32'h0,         2, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b1);
    vecs[3] = mk("rd0",     1'b0, 32'h40, 32'h0,         0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);
    vecs[4] = mk("wrerr",   1'b1, 32'h44, 32'h0102_0304, 1, 32'h7777_7777, 1'b1, 32'h0,         1'b1);
    vecs[5] = mk("rdstale", 1'b0, 32'h48, 32'h0,         2, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 1'b0);

    // Reset: cmd_valid held high must not start anything.
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_apb", {apb.psel, apb.penable, apb.pwrite}, 3'b000);
    chk("rst_paddr", apb.paddr, 0);
    chk("rst_pwdata", apb.pwdata, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst_rdata", rsp_rdata, 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_ready", cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].rdata,
            vecs[i].err, vecs[i].exp_rdata, vecs[i].exp_err);
      finish(vecs[i].name, 3 + vecs[i].waits);
    end

    // Response backpressure with a second command waiting.
    issue(1'b0, 32'h50, 32'h0, 0, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0);
    repeat (2) tick();
    chk("bp_rsp", rsp_valid, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h54; cmd_wdata = 32'h7777_8888;
    repeat (5) begin
      tick();
      chk("bp_hold", {rsp_valid, cmd_ready, apb.psel}, 3'b100);
      chk("bp_rdata", rsp_rdata, 32'h1111_2222);
    end
    x = sbq.pop_front();
    chk("bp_rdata1", rsp_rdata, x.rdata);
    chk("bp_err1", rsp_err, x.err);
    rsp_ready = 1'b1;
    cur_waits = 1; cur_addr = 32'h54; cur_write = 1'b1; cur_wdata = 32'h7777_8888; cur_err = 1'b0;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release", {rsp_valid, cmd_ready, apb.psel}, 3'b010);
    x.rdata = '0; x.err = 1'b0;
    sbq.push_back(x);
    tick();
    cmd_valid = 1'b0;
    chk("bp_accept", {apb.psel, apb.penable}, 2'b10);
    finish("bp2", 4);

`ifdef APB3_HOST_TIMEOUT_EN
    stuck = 1'b1;
    issue(1'b0, 32'h60, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1);
    finish("to_abort", 6);
    stuck = 1'b0;
    issue(1'b0, 32'h64, 32'h0, 3, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0);
    finish("to_edge", 6);
`endif

    // Reset while waiting in ACCESS: the pending response is dropped.
    issue(1'b0, 32'h70, 32'h0, 8, 32'h3333_4444, 1'b0, 32'h3333_4444, 1'b0);
    repeat (2) tick();
    chk("mid_access", {apb.psel, apb.penable}, 2'b11);
    rst = 1'b1;
    tick();
    chk("mid_rst", {apb.psel, apb.penable, rsp_valid, cmd_ready}, 4'b0000);
    rst = 1'b0;
    sbq.delete();
    repeat (3) begin
      tick();
      chk("post_rst_quiet", {rsp_valid, apb.psel}, 2'b00);
    end
    issue(1'b0, 32'h74, 32'h0, 1, 32'h600D_F00D, 1'b0, 32'h600D_F00D, 1'b0);
    finish("post_rst", 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
